// File: rtl/rf_bank_arbiter.sv
// rf_bank_arbiter: register-file bank arbiter with per-bank read request queues.
//   clk, rst (sync, active-low)
//   Src1_*/Src2_*   : operand read requests {valid, bank, row, collector tag}
//   Write*          : CDB writeback port; writes never stall and win over reads
//   Stall_RF        : combinational; this cycle's source requests are refused
//   RdValid/RdOCID/RdData : per-bank registered read return (bank b in field b)

package rf_bank_pkg;
  typedef struct packed {
    logic [2:0] row;
    logic [2:0] ocid;
  } rf_req_t;
endpackage

// rf_bank_lane: one bank -- 8x256 storage, request FIFO, registered read return.
//   acc/push1/push2/req1/req2 : enqueue controls (req1 lands ahead of req2)
//   wr_en/wr_row/wr_data      : writeback into this bank
//   cnt                       : registered queue occupancy, used for stall
//   rd_valid/rd_ocid/rd_data  : read return
module rf_bank_lane
  import rf_bank_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CW         = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          acc,
  input  logic          push1,
  input  logic          push2,
  input  rf_req_t       req1,
  input  rf_req_t       req2,
  input  logic          wr_en,
  input  logic [2:0]    wr_row,
  input  logic [255:0]  wr_data,
  output logic [CW-1:0] cnt,
  output logic          rd_valid,
  output logic [2:0]    rd_ocid,
  output logic [255:0]  rd_data
);
  localparam int PW = $clog2(FIFO_DEPTH);

  rf_req_t       q [FIFO_DEPTH];
  logic [255:0]  store [8];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] npush;
  logic          pop;
  rf_req_t       head;

  assign head  = q[rptr];
  // A write to this bank takes the storage port; the head read waits a cycle
  // and then sees the freshly written data.
  assign pop   = (cnt != '0) && !wr_en;
  assign npush = acc ? (CW'(push1) + CW'(push2)) : '0;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk)
    if (wr_en) store[wr_row] <= wr_data;

  // Queue slots hold no state of their own; pointers/count define validity.
  always_ff @(posedge clk)
    if (acc) begin
      if (push1) q[wptr] <= req1;
      if (push2) q[push1 ? wptr + PW'(1) : wptr] <= req2;
    end

  always_ff @(posedge clk)
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      rd_valid <= 1'b0;
      rd_ocid  <= '0;
      rd_data  <= '0;
    end else begin
      wptr     <= wptr + PW'(npush);
      rd_valid <= pop;
      cnt      <= cnt + npush - CW'(pop);
      if (pop) begin
        rptr    <= rptr + PW'(1);
        rd_ocid <= head.ocid;
        rd_data <= store[head.row];
      end
    end
endmodule

module rf_bank_arbiter
  import rf_bank_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int NBANK      = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Src1_Valid,
  input  logic [1:0]    Src1_Bank,
  input  logic [2:0]    Src1_Row,
  input  logic [2:0]    Src1_OCID,
  input  logic          Src2_Valid,
  input  logic [1:0]    Src2_Bank,
  input  logic [2:0]    Src2_Row,
  input  logic [2:0]    Src2_OCID,
  input  logic          WriteValid,
  input  logic [1:0]    WriteBank,
  input  logic [2:0]    WriteRow,
  input  logic [255:0]  WriteData,
  output logic          Stall_RF,
  output logic [3:0]    RdValid,
  output logic [11:0]   RdOCID,
  output logic [1023:0] RdData
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [NBANK-1:0][CW-1:0] cnt;
  logic [NBANK-1:0]         p1, p2;
  rf_req_t                  r1, r2;

  assign r1 = {Src1_Row, Src1_OCID};
  assign r2 = {Src2_Row, Src2_OCID};

  // All-or-nothing: one full bank refuses both sources. Only the registered
  // count is used, so a pop in the same cycle earns no credit.
  always_comb begin
    Stall_RF = 1'b0;
    for (int b = 0; b < NBANK; b++)
      if (({1'b0, cnt[b]} + (CW+1)'(p1[b]) + (CW+1)'(p2[b])) > (CW+1)'(FIFO_DEPTH))
        Stall_RF = 1'b1;
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    assign p1[b] = Src1_Valid && (Src1_Bank == 2'(b));
    assign p2[b] = Src2_Valid && (Src2_Bank == 2'(b));

    rf_bank_lane #(.FIFO_DEPTH(FIFO_DEPTH), .CW(CW)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .acc      (!Stall_RF),
      .push1    (p1[b]),
      .push2    (p2[b]),
      .req1     (r1),
      .req2     (r2),
      .wr_en    (WriteValid && (WriteBank == 2'(b))),
      .wr_row   (WriteRow),
      .wr_data  (WriteData),
      .cnt      (cnt[b]),
      .rd_valid (RdValid[b]),
      .rd_ocid  (RdOCID[3*b +: 3]),
      .rd_data  (RdData[256*b +: 256])
    );
  end
endmodule
